// File: rtl/texture_reverse_lookup.sv
// Reverse texture lookup: scans the block/face forward table and streams every match, then a terminator beat.
// Build option REVLOOKUP_SKIP_AIR_EN: when defined, the scan starts at block 2 (index 6), skipping blocks 0 and 1.
module texture_reverse_lookup #(
   parameter int NUM_BLOCKS = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [4:0] req_texture_id,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [4:0] rsp_block_id,
   output logic [1:0] rsp_face,
   output logic       rsp_last
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_EMIT,
      ST_TERM
   } state_t;

   localparam logic [4:0] LAST_BLK = 5'(NUM_BLOCKS - 1);
`ifdef REVLOOKUP_SKIP_AIR_EN
   localparam logic [4:0] START_BLK = 5'd2;
`else
   localparam logic [4:0] START_BLK = 5'd0;
`endif

   // Packs one table row as {face2, face1, face0}.
   function automatic logic [14:0] tri3(input logic [4:0] f0, input logic [4:0] f1, input logic [4:0] f2);
      return {f2, f1, f0};
   endfunction

   function automatic logic [14:0] fwd_row(input logic [4:0] blk);
      logic [14:0] row;
      row = '0;
      case (blk)
         5'd2:  row = tri3(5'd2, 5'd3, 5'd1);
         5'd3:  row = tri3(5'd3, 5'd3, 5'd3);
         5'd4, 5'd5, 5'd6, 5'd7:
                row = tri3(blk, blk, blk);
         5'd8:  row = tri3(5'd9, 5'd8, 5'd8);
         5'd9:  row = tri3(5'd11, 5'd10, 5'd10);
         5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18:
                row = tri3(blk + 5'd2, blk + 5'd2, blk + 5'd2);
         5'd19: row = tri3(5'd22, 5'd23, 5'd21);
         5'd20: row = tri3(5'd24, 5'd7, 5'd7);
         5'd21: row = tri3(5'd27, 5'd7, 5'd25);
         5'd22: row = tri3(5'd30, 5'd28, 5'd28);
         5'd23: row = tri3(5'd31, 5'd31, 5'd31);
         default: row = '0;
      endcase
      return row;
   endfunction

   state_t      r_state;
   logic [4:0]  r_tex;
   logic [4:0]  r_blk;
   logic [1:0]  r_face;
   logic        r_rsp_valid;
   logic        r_rsp_last;
   logic [4:0]  r_rsp_blk;
   logic [1:0]  r_rsp_face;

   logic [14:0] w_row;
   logic [4:0]  w_cand_tex;
   logic        w_hit;
   logic        w_idx_last;
   logic [4:0]  w_blk_next;
   logic [1:0]  w_face_next;

   assign w_row = fwd_row(r_blk);

   always_comb begin
      w_cand_tex = w_row[14:10];
      case (r_face)
         2'd0:    w_cand_tex = w_row[4:0];
         2'd1:    w_cand_tex = w_row[9:5];
         default: w_cand_tex = w_row[14:10];
      endcase
   end

   assign w_hit       = (w_cand_tex == r_tex);
   assign w_idx_last  = (r_blk == LAST_BLK) && (r_face == 2'd2);
   // The scan index block*3+face is kept as a (block, face) pair so no divide is needed.
   assign w_blk_next  = (r_face == 2'd2) ? r_blk + 5'd1 : r_blk;
   assign w_face_next = (r_face == 2'd2) ? 2'd0 : r_face + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_tex       <= '0;
         r_blk       <= '0;
         r_face      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_rsp_blk   <= '0;
         r_rsp_face  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_tex   <= req_texture_id;
                  r_blk   <= START_BLK;
                  r_face  <= 2'd0;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (w_hit) begin
                  r_rsp_blk   <= r_blk;
                  r_rsp_face  <= r_face;
                  r_rsp_last  <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_EMIT;
               end else if (w_idx_last) begin
                  r_rsp_blk   <= '0;
                  r_rsp_face  <= '0;
                  r_rsp_last  <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_TERM;
               end else begin
                  r_blk  <= w_blk_next;
                  r_face <= w_face_next;
               end
            end
            ST_EMIT: begin
               if (rsp_ready) begin
                  if (w_idx_last) begin
                     r_rsp_blk  <= '0;
                     r_rsp_face <= '0;
                     r_rsp_last <= 1'b1;
                     r_state    <= ST_TERM;
                  end else begin
                     r_blk       <= w_blk_next;
                     r_face      <= w_face_next;
                     r_rsp_valid <= 1'b0;
                     r_state     <= ST_SCAN;
                  end
               end
            end
            ST_TERM: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = (r_state == ST_IDLE);
   assign rsp_valid    = r_rsp_valid;
   assign rsp_last     = r_rsp_last;
   assign rsp_block_id = r_rsp_blk;
   assign rsp_face     = r_rsp_face;

endmodule

// File: tb/tb_texture_reverse_lookup.sv
// Directed bench for texture_reverse_lookup: hit streams, terminator timing, stalls and mid-scan reset.
module tb_texture_reverse_lookup;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] req_texture_id;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [4:0] rsp_block_id;
   logic [1:0] rsp_face;
   logic       rsp_last;

   int n_checks = 0;
   int n_errors = 0;
   int got_q[$];
   int exp_q[$];

   always #5 clk = ~clk;

   texture_reverse_lookup #(.NUM_BLOCKS(24)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_texture_id (req_texture_id),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_block_id   (rsp_block_id),
      .rsp_face       (rsp_face),
      .rsp_last       (rsp_last)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic compare_beats(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         check($sformatf("%s_beat%0d", tag, k), got_q[k], exp_q[k]);
   endtask

   // Beats are recorded as block*4+face; the terminator must carry zero data.
   task automatic run_lookup(input string tag, input logic [4:0] tex, input bit rnd,
                             input bit hold_busy, output int first_edge);
      int         edges;
      bit         done;
      bit         stalled;
      bit         nr;
      logic [4:0] s_blk;
      logic [1:0] s_face;
      logic       s_last;
      got_q.delete();
      first_edge = -1;
      edges = 0; done = 0; stalled = 0;
      s_blk = '0; s_face = '0; s_last = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_texture_id = tex; rsp_ready = 1'b1;
      check({tag, "_ready_idle"}, int'(req_ready), 1);
      @(posedge clk); #1;
      if (hold_busy) req_texture_id = 5'd3;
      else req_valid = 1'b0;
      while (!done && edges < 300) begin
         @(posedge clk); edges++;
         @(negedge clk);
         if (edges == 1) check({tag, "_busy"}, int'(req_ready), 0);
         if (rsp_valid && first_edge < 0) first_edge = edges;
         if (stalled) begin
            check({tag, "_stall_valid"}, int'(rsp_valid), 1);
            check({tag, "_stall_blk"}, int'(rsp_block_id), int'(s_blk));
            check({tag, "_stall_face"}, int'(rsp_face), int'(s_face));
            check({tag, "_stall_last"}, int'(rsp_last), int'(s_last));
         end
         nr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         rsp_ready = nr;
         stalled = rsp_valid && !nr;
         s_blk = rsp_block_id; s_face = rsp_face; s_last = rsp_last;
         if (rsp_valid && nr) begin
            if (rsp_last) begin
               check({tag, "_term_data"}, int'(rsp_block_id) * 4 + int'(rsp_face), 0);
               done = 1'b1;
               req_valid = 1'b0;
            end else begin
               got_q.push_back(int'(rsp_block_id) * 4 + int'(rsp_face));
            end
         end
      end
      req_valid = 1'b0;
      check({tag, "_done"}, int'(done), 1);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_end_valid"}, int'(rsp_valid), 0);
      check({tag, "_end_ready"}, int'(req_ready), 1);
      compare_beats(tag);
   endtask

   initial begin
      int fe;
      int beats;
      int edges;
      bit seen;
      rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_texture_id = '0;

      // Reset asserted mid-clock must take effect without an edge.
      #12 rst_n = 1'b0;
      #1;
      check("rst_valid", int'(rsp_valid), 0);
      check("rst_ready", int'(req_ready), 1);
      check("rst_last", int'(rsp_last), 0);
      check("rst_blk", int'(rsp_block_id), 0);
      check("rst_face", int'(rsp_face), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      exp_q = '{9, 12, 13, 14};
      run_lookup("tex3", 5'd3, 1'b0, 1'b0, fe);
`ifdef REVLOOKUP_SKIP_AIR_EN
      check("tex3_first_edge", fe, 2);
`else
      check("tex3_first_edge", fe, 8);
`endif

      exp_q = '{28, 29, 30, 81, 82, 85};
      run_lookup("tex7", 5'd7, 1'b0, 1'b0, fe);

      // Texture 26 has no hits; a held request for texture 3 must be ignored while busy.
      exp_q.delete();
      run_lookup("tex26", 5'd26, 1'b0, 1'b1, fe);
`ifdef REVLOOKUP_SKIP_AIR_EN
      check("tex26_term_edge", fe, 66);
`else
      check("tex26_term_edge", fe, 72);
`endif

`ifdef REVLOOKUP_SKIP_AIR_EN
      exp_q.delete();
`else
      exp_q = '{0, 1, 2, 4, 5, 6};
`endif
      run_lookup("tex0_rnd", 5'd0, 1'b1, 1'b0, fe);
`ifdef REVLOOKUP_SKIP_AIR_EN
      check("tex0_first_edge", fe, 66);
`else
      check("tex0_first_edge", fe, 1);
`endif

      // Abort texture 7 right after its second beat is consumed.
      @(negedge clk);
      req_valid = 1'b1; req_texture_id = 5'd7; rsp_ready = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      beats = 0; edges = 0;
      while (beats < 2 && edges < 200) begin
         @(negedge clk); edges++;
         if (rsp_valid && rsp_ready) beats++;
      end
      check("abort_two_beats", beats, 2);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", int'(rsp_valid), 0);
      check("abort_ready", int'(req_ready), 1);
      check("abort_last", int'(rsp_last), 0);
      check("abort_data", int'(rsp_block_id) * 4 + int'(rsp_face), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("abort_no_beats", int'(seen), 0);
      check("abort_idle_ready", int'(req_ready), 1);

      exp_q = '{9, 12, 13, 14};
      run_lookup("tex3_after_rst", 5'd3, 1'b0, 1'b0, fe);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/texture_reverse_lookup.md
TEXTURE_REVERSE_LOOKUP -- requirements
Module: texture_reverse_lookup

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameter NUM_BLOCKS, default 24, is the count of block ids scanned, legal range 1..32.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  asynchronous reset, active low.
REQ-005 req_valid  input  1  lookup request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_texture_id  input  5  texture id to reverse-map.
REQ-008 rsp_valid  output  1  response beat present.
REQ-009 rsp_ready  input  1  consumer accepts the beat.
REQ-010 rsp_block_id  output  5  matching block id; 0 on the terminator beat.
REQ-011 rsp_face  output  2  matching face; 0 on the terminator beat.
REQ-012 rsp_last  output  1  1 = terminator beat (no match data), 0 = hit beat.

Function
REQ-013 Internal forward table, as block:(face0,face1,face2) textures: 0:(0,0,0) 1:(0,0,0) 2:(2,3,1) 3:(3,3,3) 4:4 5:5 6:6 7:7 8:(9,8,8) 9:(11,10,10) 10:12 11:13 12:14 13:15 14:16 15:17 16:18 17:19 18:20 19:(22,23,21) 20:(24,7,7) 21:(27,7,25) 22:(30,28,28) 23:31; blocks 24..31 map to 0 on all faces. A single number means all three faces; face 3 is never scanned.
REQ-014 Scan index i = block*3 + face covers 0..3*NUM_BLOCKS-1 in ascending order, so hits are emitted in ascending block, then face, order.
REQ-015 States: IDLE, SCAN, EMIT, TERM.
REQ-016 req_ready = 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1. On that edge the texture is captured, i is set to the start index and the state goes to SCAN.
REQ-017 In SCAN the block evaluates one candidate per edge:
- match: load rsp_block_id and rsp_face, set rsp_last=0 and rsp_valid=1, go to EMIT, hold i.
- no match and i not last: increment i.
- no match and i last: load the terminator beat, set rsp_valid=1, go to TERM.
REQ-018 In EMIT, on handshake (rsp_valid and rsp_ready):
- i last: load the terminator in the same edge, rsp_valid stays 1, go to TERM.
- otherwise: increment i, set rsp_valid=0, go to SCAN.
REQ-019 In TERM, on handshake: rsp_valid=0, go to IDLE.
REQ-020 While rsp_valid=1 and rsp_ready=0, every rsp_* output SHALL hold stable.
REQ-021 Every accepted request SHALL yield all hit beats and then exactly one terminator beat; requests arriving while busy are not accepted.
REQ-022 Latency: the first candidate is evaluated on the first edge after acceptance. A miss costs 1 cycle; a hit is visible the cycle after its evaluation edge.

Reset
REQ-023 While rst_n=0, the block SHALL be held in IDLE regardless of clk, with:
- rsp_valid=0, rsp_last=0, rsp_block_id=0, rsp_face=0
- req_ready=1, i=0, captured texture=0
REQ-024 A reset asserted mid-scan or mid-emit SHALL abort the request immediately; no terminator is emitted.

Configuration
REQ-025 Macro REVLOOKUP_SKIP_AIR_EN:
- When defined, the scan starts at i=6, excluding blocks 0 and 1.
- When undefined, the scan starts at i=0.
- Terminator behaviour is identical in both builds.

Verification
REQ-026 Reset: assert rst_n=0 mid-clock -> rsp_valid=0 and req_ready=1 immediately.
REQ-027 Request texture 3 with rsp_ready=1 -> beats (2,1),(3,0),(3,1),(3,2), then rsp_last=1.
REQ-028 Request texture 7 -> beats (7,0),(7,1),(7,2),(20,1),(20,2),(21,1), then terminator.
REQ-029 Request texture 26 with the macro undefined -> only a terminator, rsp_valid rising on the 72nd edge after acceptance; 66th edge with the macro defined.
REQ-030 Texture 0 request:
- macro undefined -> six hits (0,0)..(1,2) plus terminator.
- macro defined -> terminator only.
- with rsp_ready toggled randomly, beats stay stable while stalled.
REQ-031 rst_n pulsed low during the texture 7 scan after the second beat -> no further beats, IDLE, and a new request is accepted normally.
